param_serializer: RTL
=====================

PARAM_SERIALIZER -- requirements
Module: param_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width; legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 0; 0 shifts LSB first, 1 shifts MSB first.
REQ-003 SHALL have parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity.
REQ-004 SHALL have port CLK  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port P_DATA  input  WIDTH  parallel word to send.
REQ-007 SHALL have port Data_Valid  input  1  P_DATA is offered.
REQ-008 SHALL have port Data_Ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have port Bit_Tick  input  1  advance one bit slot (baud enable).
REQ-010 SHALL have port ser_data  output  1  serial bit; idle level 1.
REQ-011 SHALL have port ser_active  output  1  a frame (data, plus parity if enabled) is on ser_data.
REQ-012 SHALL have port ser_done  output  1  one-cycle pulse when a frame completes.

Function
REQ-013 SHALL accept a word on any rising edge where Data_Valid=1 and Data_Ready=1, writing it into a one-entry hold register.
REQ-014 SHALL drive Data_Ready = NOT hold_full, from registered state only; there is no combinational path from Data_Valid.
REQ-015 SHALL use FSM states IDLE, SHIFT and PARITY; ser_active=1 exactly in SHIFT and PARITY.
REQ-016 In IDLE with hold_full=1, SHALL on the next edge load the shifter from hold, clear hold_full, reset bit_cnt to 0, latch parity and enter SHIFT; accept-to-ser_active latency is 2 cycles.
REQ-017 Parity SHALL be computed at load time as the XOR of all WIDTH bits (even), inverted when PARITY_ODD=1.
REQ-018 In SHIFT, ser_data SHALL be shreg[0] (MSB_FIRST=0) or shreg[WIDTH-1] (MSB_FIRST=1); each Bit_Tick shifts one position and increments bit_cnt.
REQ-019 bit_cnt SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap; the tick at bit_cnt=WIDTH-1 ends the data phase.
REQ-020 The end of the data phase SHALL go to PARITY if SER_PARITY_EN is defined, otherwise it ends the frame.
REQ-021 In PARITY, ser_data SHALL equal the latched parity bit; the next Bit_Tick ends the frame.
REQ-022 At frame end, ser_done SHALL pulse high for exactly one cycle, on the cycle after the final tick.
REQ-023 At frame end with hold_full=1, SHALL reload immediately and stay in SHIFT, giving back-to-back frames with no idle bit.
REQ-024 At frame end with hold_full=0, SHALL enter IDLE, where ser_data=1.
REQ-025 Bit_Tick in IDLE, and on a load edge, SHALL be ignored.
REQ-026 A word SHALL be acceptable into hold during SHIFT and PARITY, so at most one frame plus one word is buffered.

Reset
REQ-027 RST=1 at an edge SHALL force IDLE, hold_full=0, shreg=0, bit_cnt=0 and parity=0.
REQ-028 Outputs after reset SHALL be ser_data=1, ser_active=0, ser_done=0, Data_Ready=1.
REQ-029 RST SHALL take priority over all other inputs, SHALL abort any frame in progress and SHALL discard the held word with no ser_done.

Configuration
REQ-030 Macro SER_PARITY_EN defined SHALL compile in the PARITY state and parity logic, making frames WIDTH+1 bit slots.
REQ-031 With SER_PARITY_EN undefined, the PARITY state and parity register SHALL be absent and frames SHALL be WIDTH bit slots; all ports are unchanged.

Structure
REQ-032 Shared package ser_pkg SHALL hold the state typedef (IDLE, SHIFT, PARITY) and the constant SER_IDLE_LEVEL=1.
REQ-033 The hold register and its valid/ready logic SHALL be sub-module ser_hold_buf, parameterised by WIDTH.

Verification
REQ-034 Test 1: WIDTH=8, LSB-first, parity off, send 0xA5, Bit_Tick every 4 cycles -> ser_data 1,0,1,0,0,1,0,1; ser_done pulses once; ser_active stays high for 8 slots.
REQ-035 Test 2: MSB_FIRST=1, SER_PARITY_EN defined, even parity, send 0xA5 -> ser_data 1,0,1,0,0,1,0,1 then parity slot 0; with PARITY_ODD=1 the parity slot is 1.
REQ-036 Test 3: send 0x3C and 0xC3 back-to-back with Data_Valid held -> Data_Ready drops while hold is full; 16 contiguous data slots with no idle 1 between frames; two ser_done pulses.
REQ-037 Test 4: WIDTH=5, send 5'h11 with Bit_Tick held high continuously -> one bit per cycle; ser_done arrives 5 cycles after the first SHIFT cycle; bit_cnt never exceeds 4.
REQ-038 Test 5: assert RST mid-frame after 3 ticks with a word held -> the next cycle shows ser_data=1, ser_active=0, Data_Ready=1; no ser_done ever follows.

Source files
------------

// File: rtl/ser_pkg.sv
// Shared types and constants for the parameterised serializer.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_e;

  localparam logic SER_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding register in front of the shifter; ready depends only on registered state.
module ser_hold_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  output logic             Data_Ready,
  input  logic             take,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full
);

  // take and accept never coincide: take needs a full hold, accept an empty one
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (take) begin
      hold_full <= 1'b0;
    end else if (Data_Valid && !hold_full) begin
      hold_full <= 1'b1;
      hold_data <= P_DATA;
    end
  end

  assign Data_Ready = !hold_full;

endmodule

// File: rtl/param_serializer.sv
// Parallel-to-serial shifter paced by Bit_Tick, with a one-word hold buffer.
// Define SER_PARITY_EN to append a parity slot after the data bits.
module param_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MSB_FIRST  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  output logic             Data_Ready,
  input  logic             Bit_Tick,
  output logic             ser_data,
  output logic             ser_active,
  output logic             ser_done
);

  localparam int unsigned       CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  generate
    if (WIDTH < 2 || WIDTH > 32 || MSB_FIRST > 1 || PARITY_ODD > 1) begin : g_bad_cfg
      $error("param_serializer: parameter out of range");
    end
  endgenerate

  ser_state_e       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             take;
  logic             frame_end;
  logic [WIDTH-1:0] shreg_shift;
  logic             shift_bit;
  logic             load_bit;
`ifdef SER_PARITY_EN
  logic             parity;
  logic             load_parity;
`endif

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .Data_Ready (Data_Ready),
    .take       (take),
    .hold_data  (hold_data),
    .hold_full  (hold_full)
  );

  // Shift direction, next visible bit, and load/reload decision
  always_comb begin
    shreg_shift = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
    shift_bit   = (MSB_FIRST != 0) ? shreg[WIDTH-2] : shreg[1];
    load_bit    = (MSB_FIRST != 0) ? hold_data[WIDTH-1] : hold_data[0];
`ifdef SER_PARITY_EN
    load_parity = (^hold_data) ^ (PARITY_ODD != 0);
    frame_end   = (state == PARITY) && Bit_Tick;
`else
    frame_end   = (state == SHIFT) && Bit_Tick && (bit_cnt == LAST_BIT);
`endif
    take        = hold_full && ((state == IDLE) || frame_end);
  end

  // Frame FSM; ser_data always carries the bit of the slot currently on the line
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      ser_data   <= SER_IDLE_LEVEL;
      ser_active <= 1'b0;
      ser_done   <= 1'b0;
`ifdef SER_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      ser_done <= 1'b0;
      if (take) begin
        state      <= SHIFT;
        shreg      <= hold_data;
        bit_cnt    <= '0;
        ser_data   <= load_bit;
        ser_active <= 1'b1;
        ser_done   <= frame_end;
`ifdef SER_PARITY_EN
        parity     <= load_parity;
`endif
      end else begin
        case (state)
          IDLE: begin
            ser_data   <= SER_IDLE_LEVEL;
            ser_active <= 1'b0;
          end
          SHIFT: begin
            if (Bit_Tick) begin
              if (bit_cnt != LAST_BIT) begin
                shreg    <= shreg_shift;
                bit_cnt  <= bit_cnt + CNT_W'(1);
                ser_data <= shift_bit;
              end else begin
`ifdef SER_PARITY_EN
                state      <= PARITY;
                ser_data   <= parity;
`else
                state      <= IDLE;
                ser_data   <= SER_IDLE_LEVEL;
                ser_active <= 1'b0;
                ser_done   <= 1'b1;
`endif
              end
            end
          end
`ifdef SER_PARITY_EN
          PARITY: begin
            if (Bit_Tick) begin
              state      <= IDLE;
              ser_data   <= SER_IDLE_LEVEL;
              ser_active <= 1'b0;
              ser_done   <= 1'b1;
            end
          end
`endif
          default: begin
            state      <= IDLE;
            ser_data   <= SER_IDLE_LEVEL;
            ser_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
